// File: rtl/canvas_pkg.sv
// Shared canvas geometry, request bundle and stamp FSM encoding for the
// brush-stamping path into the framebuffer.
package canvas_pkg;
    localparam int H_RES   = 640;
    localparam int V_RES   = 360;
    localparam int ADDR_W  = 18;
    localparam int COLOR_W = 4;
    localparam int BRUSH_W = 3;
    localparam int X_W     = 10;
    localparam int Y_W     = 9;

    typedef struct packed {
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [COLOR_W-1:0] color;
        logic [BRUSH_W-1:0] width;
    } stamp_req_t;

    typedef enum logic {
        IDLE  = 1'b0,
        STAMP = 1'b1
    } stamp_state_t;
endpackage

// File: rtl/stroke_stamp_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins outright, a tie goes to
// the requester that did not win last time.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       rr_last,
    output logic [1:0] grant,
    output logic       winner
);
    always_comb begin
        grant  = 2'b00;
        winner = 1'b0;
        case (valid)
            2'b01: begin
                grant  = 2'b01;
                winner = 1'b0;
            end
            2'b10: begin
                grant  = 2'b10;
                winner = 1'b1;
            end
            2'b11: begin
                winner = ~rr_last;
                grant  = rr_last ? 2'b01 : 2'b10;
            end
            default: begin
                grant  = 2'b00;
                winner = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/stroke_stamp_arbiter.sv
// Arbitrates two cursor sources onto the canvas write port and stamps a
// clipped square brush one pixel per cycle, honouring write backpressure.
module stroke_stamp_arbiter
    import canvas_pkg::*;
#(
    parameter int H_RES  = 640,
    parameter int V_RES  = 360,
    parameter int ADDR_W = 18
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic [1:0]             req_valid_in,
    output logic [1:0]             req_ready_out,
    input  logic [1:0][9:0]        req_x_in,
    input  logic [1:0][8:0]        req_y_in,
    input  logic [1:0][3:0]        req_color_in,
    input  logic [1:0][2:0]        req_width_in,
    output logic                   fb_we_out,
    output logic [ADDR_W-1:0]      fb_addr_out,
    output logic [3:0]             fb_data_out,
    input  logic                   fb_ready_in,
    output logic                   busy_out,
    output logic [1:0]             done_out
);
    stamp_state_t state, state_nxt;

    logic [1:0]        grant;
    logic              winner;
    logic              rr_last;
    logic              win_r;
    logic              hs;
    logic              last_px;

    stamp_req_t        sel;
    logic [9:0]        xc, x0, x1;
    logic [8:0]        yc, y0, y1;
    logic signed [10:0] x_lo, y_lo;
    logic [10:0]       x_hi, y_hi;
    logic [ADDR_W-1:0] base;

    logic [9:0]        cur_x, x0_r, x1_r;
    logic [8:0]        cur_y, y1_r;
    logic [ADDR_W-1:0] row_base;

    rr_arb2 u_arb (
        .valid   (req_valid_in),
        .rr_last (rr_last),
        .grant   (grant),
        .winner  (winner)
    );

    // Box for the winning request; only consumed in the accept cycle, so the
    // one multiply for the first row base lives here, off the per-pixel path.
    always_comb begin
        sel.x     = req_x_in[winner];
        sel.y     = req_y_in[winner];
        sel.color = req_color_in[winner];
        sel.width = req_width_in[winner];
        xc   = (sel.x > 10'(H_RES - 1)) ? 10'(H_RES - 1) : sel.x;
        yc   = (sel.y > 9'(V_RES - 1))  ? 9'(V_RES - 1)  : sel.y;
        x_lo = $signed({1'b0, xc}) - $signed({8'b0, sel.width});
        y_lo = $signed({2'b0, yc}) - $signed({8'b0, sel.width});
        x_hi = {1'b0, xc} + {8'b0, sel.width};
        y_hi = {2'b0, yc} + {8'b0, sel.width};
        x0   = (x_lo < 0) ? 10'd0 : x_lo[9:0];
        y0   = (y_lo < 0) ? 9'd0  : y_lo[8:0];
        x1   = (x_hi > 11'(H_RES - 1)) ? 10'(H_RES - 1) : x_hi[9:0];
        y1   = (y_hi > 11'(V_RES - 1)) ? 9'(V_RES - 1)  : y_hi[8:0];
        base = ADDR_W'(y0) * ADDR_W'(H_RES);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        req_ready_out = 2'b00;
        hs            = 1'b0;
        last_px       = 1'b0;
        case (state)
            IDLE: begin
                req_ready_out = grant;
                hs            = |grant;
                if (hs) state_nxt = STAMP;
            end
            STAMP: begin
                last_px = fb_ready_in && (cur_x == x1_r) && (cur_y == y1_r);
                if (last_px) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign fb_we_out = (state == STAMP);
    assign busy_out  = (state == STAMP);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rr_last     <= 1'b1;
            win_r       <= 1'b0;
            cur_x       <= '0;
            cur_y       <= '0;
            x0_r        <= '0;
            x1_r        <= '0;
            y1_r        <= '0;
            row_base    <= '0;
            fb_addr_out <= '0;
            fb_data_out <= '0;
            done_out    <= 2'b00;
        end else begin
            done_out <= 2'b00;
            if (hs) begin
                rr_last     <= winner;
                win_r       <= winner;
                cur_x       <= x0;
                cur_y       <= y0;
                x0_r        <= x0;
                x1_r        <= x1;
                y1_r        <= y1;
                row_base    <= base;
                fb_addr_out <= base + ADDR_W'(x0);
                fb_data_out <= sel.color;
            end else if (state == STAMP && fb_ready_in) begin
                if (cur_x != x1_r) begin
                    cur_x       <= cur_x + 10'd1;
                    fb_addr_out <= fb_addr_out + ADDR_W'(1);
                end else if (cur_y != y1_r) begin
                    cur_y       <= cur_y + 9'd1;
                    cur_x       <= x0_r;
                    row_base    <= row_base + ADDR_W'(H_RES);
                    fb_addr_out <= row_base + ADDR_W'(H_RES) + ADDR_W'(x0_r);
                end else begin
                    done_out <= win_r ? 2'b10 : 2'b01;
                end
            end
        end
    end
endmodule
